// File: rtl/uart_pkg.sv
// Shared UART constants and TX state encoding, used by both the TX and RX sides.
package uart_pkg;

   localparam int UART_DBIT    = 8;
   localparam int UART_OS      = 16;
   localparam int UART_SB_TICK = 16;
   localparam int UART_DVSR    = 163;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_t;

   // Width of a counter that has to hold values 0..max_val-1.
   function automatic int cnt_width(input int max_val);
      return (max_val > 1) ? $clog2(max_val) : 1;
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversampling tick generator: one-clock pulse every DVSR clocks.
module uart_baud_tick
   import uart_pkg::*;
#(
   parameter int DVSR = UART_DVSR
) (
   input  logic i_clk,
   input  logic i_reset_n,
   output logic o_tick
);

   localparam int            CW   = cnt_width(DVSR);
   localparam logic [CW-1:0] LAST = CW'(DVSR - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n)
         cnt <= '0;
      else if (cnt == LAST)
         cnt <= '0;
      else
         cnt <= cnt + CW'(1);
   end

   assign o_tick = (cnt == LAST);

endmodule

// File: rtl/uart_tx_drain.sv
// UART transmitter that drains a first-word-fall-through TX FIFO, LSB first.
// Define UART_TX_PARITY_EN to insert a parity bit between data and stop.
//
// state     | meaning
// ST_IDLE   | line high, pop and latch a word as soon as the FIFO is non-empty
// ST_START  | line low for OS ticks (first bit may be up to one tick short)
// ST_DATA   | shreg[0] on the line, DBIT bits of OS ticks each
// ST_PARITY | latched parity bit for OS ticks (parity build only)
// ST_STOP   | line high for SB_TICK ticks, then done pulse and back to idle
module uart_tx_drain
   import uart_pkg::*;
#(
   parameter int DBIT    = UART_DBIT,
   parameter int SB_TICK = UART_SB_TICK,
   parameter int OS      = UART_OS,
   parameter int DVSR    = UART_DVSR
`ifdef UART_TX_PARITY_EN
   ,
   parameter bit PARITY_ODD = 1'b0
`endif
) (
   input  logic            i_clk,
   input  logic            i_reset_n,
   input  logic            i_fifo_empty,
   input  logic [DBIT-1:0] i_fifo_data,
   output logic            o_fifo_rd,
   output logic            o_tx,
   output logic            o_busy,
   output logic            o_tx_done_tick
);

   localparam int            SMAX        = (OS > SB_TICK) ? OS : SB_TICK;
   localparam int            SW          = cnt_width(SMAX);
   localparam int            NW          = cnt_width(DBIT);
   localparam logic [SW-1:0] S_BIT_LAST  = SW'(OS - 1);
   localparam logic [SW-1:0] S_STOP_LAST = SW'(SB_TICK - 1);
   localparam logic [NW-1:0] N_LAST      = NW'(DBIT - 1);

   uart_state_t     state;
   logic [SW-1:0]   s_cnt;
   logic [NW-1:0]   n_cnt;
   logic [DBIT-1:0] shreg;
   logic            tx_reg;
   logic            done_reg;
   logic            tick;
`ifdef UART_TX_PARITY_EN
   logic            par_reg;
`endif

   uart_baud_tick #(.DVSR(DVSR)) u_baud (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .o_tick    (tick)
   );

   // The pop is combinational so the FIFO advances on the same edge we latch its head.
   assign o_fifo_rd      = (state == ST_IDLE) && !i_fifo_empty;
   assign o_busy         = (state != ST_IDLE);
   assign o_tx           = tx_reg;
   assign o_tx_done_tick = done_reg;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state    <= ST_IDLE;
         s_cnt    <= '0;
         n_cnt    <= '0;
         shreg    <= '0;
         tx_reg   <= 1'b1;
         done_reg <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_reg  <= 1'b0;
`endif
      end else begin
         done_reg <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (!i_fifo_empty) begin
                  shreg  <= i_fifo_data;
`ifdef UART_TX_PARITY_EN
                  par_reg <= (^i_fifo_data) ^ PARITY_ODD;
`endif
                  s_cnt  <= '0;
                  tx_reg <= 1'b0;
                  state  <= ST_START;
               end
            end
            ST_START: begin
               if (tick) begin
                  if (s_cnt == S_BIT_LAST) begin
                     s_cnt  <= '0;
                     n_cnt  <= '0;
                     tx_reg <= shreg[0];
                     state  <= ST_DATA;
                  end else begin
                     s_cnt <= s_cnt + SW'(1);
                  end
               end
            end
            ST_DATA: begin
               if (tick) begin
                  if (s_cnt == S_BIT_LAST) begin
                     s_cnt <= '0;
                     shreg <= shreg >> 1;
                     if (n_cnt == N_LAST) begin
`ifdef UART_TX_PARITY_EN
                        tx_reg <= par_reg;
                        state  <= ST_PARITY;
`else
                        tx_reg <= 1'b1;
                        state  <= ST_STOP;
`endif
                     end else begin
                        n_cnt  <= n_cnt + NW'(1);
                        tx_reg <= shreg[1];
                     end
                  end else begin
                     s_cnt <= s_cnt + SW'(1);
                  end
               end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
               if (tick) begin
                  if (s_cnt == S_BIT_LAST) begin
                     s_cnt  <= '0;
                     tx_reg <= 1'b1;
                     state  <= ST_STOP;
                  end else begin
                     s_cnt <= s_cnt + SW'(1);
                  end
               end
            end
`endif
            ST_STOP: begin
               if (tick) begin
                  if (s_cnt == S_STOP_LAST) begin
                     s_cnt    <= '0;
                     done_reg <= 1'b1;
                     state    <= ST_IDLE;
                  end else begin
                     s_cnt <= s_cnt + SW'(1);
                  end
               end
            end
            default: begin
               tx_reg <= 1'b1;
               state  <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_drain.sv
// Scoreboard bench for uart_tx_drain: a FIFO model feeds words, a line monitor decodes frames.
module tb_uart_tx_drain;

   localparam int DBIT     = 8;
   localparam int OS       = 16;
   localparam int SB_TICK  = 16;
   localparam int DVSR     = 4;
   localparam int BIT_CLKS = OS * DVSR;
`ifdef UART_TX_PARITY_EN
   localparam int NB      = DBIT + 1;
   localparam bit PAR_ODD = 1'b0;
`else
   localparam int NB      = DBIT;
`endif
   localparam int DONE_MAX = BIT_CLKS * (NB + 1) + SB_TICK * DVSR;
   localparam int DONE_MIN = DONE_MAX - (DVSR - 1);

   logic            i_clk;
   logic            i_reset_n;
   logic            i_fifo_empty;
   logic [DBIT-1:0] i_fifo_data;
   logic            o_fifo_rd;
   logic            o_tx;
   logic            o_busy;
   logic            o_tx_done_tick;

   uart_tx_drain #(
      .DBIT       (DBIT),
      .SB_TICK    (SB_TICK),
      .OS         (OS),
      .DVSR       (DVSR)
`ifdef UART_TX_PARITY_EN
      ,
      .PARITY_ODD (PAR_ODD)
`endif
   ) dut (
      .i_clk          (i_clk),
      .i_reset_n      (i_reset_n),
      .i_fifo_empty   (i_fifo_empty),
      .i_fifo_data    (i_fifo_data),
      .o_fifo_rd      (o_fifo_rd),
      .o_tx           (o_tx),
      .o_busy         (o_busy),
      .o_tx_done_tick (o_tx_done_tick)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   typedef struct {
      logic [7:0] word;
      bit         b2b;
      bit         par;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] fifo_q[$];
   int         compared     = 0;
   int         mismatched   = 0;
   int         pops         = 0;
   int         illegal_pops = 0;
   int         done_cnt     = 0;
   int         frames_exp   = 0;
   int         idle_bad     = 0;
   int         cyc          = 0;
   int         last_done    = -100;

   always @(posedge i_clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int req);
      compared++;
      if (act != req) begin
         mismatched++;
         $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic push_word(input logic [7:0] w, input bit b2b, input bit par);
      exp_t e;
      e.word = w;
      e.b2b  = b2b;
      e.par  = par;
      fifo_q.push_back(w);
      exp_q.push_back(e);
      frames_exp++;
   endtask

   task automatic wait_drain(input int limit);
      int n = 0;
      while ((exp_q.size() != 0 || fifo_q.size() != 0 || o_busy) && n < limit) begin
         @(negedge i_clk);
         n++;
      end
      check("drain_in_time", int'(n < limit), 1);
      repeat (4) @(negedge i_clk);
   endtask

   task automatic wait_pops(input int target, input int limit);
      int n = 0;
      while (pops < target && n < limit) begin
         @(negedge i_clk);
         n++;
      end
      check("pop_in_time", int'(n < limit), 1);
   endtask

   // FIFO model: first-word-fall-through head, popped on the edge after o_fifo_rd is seen.
   initial begin : fifo_model
      bit rd_seen;
      i_fifo_empty = 1'b1;
      i_fifo_data  = '0;
      forever begin
         @(negedge i_clk);
         rd_seen = (o_fifo_rd === 1'b1) && (i_reset_n === 1'b1);
         if (rd_seen) pops++;
         if (o_fifo_rd === 1'b1 && i_fifo_empty) illegal_pops++;
         if (i_reset_n === 1'b1 && o_tx_done_tick === 1'b1) done_cnt++;
         @(posedge i_clk);
         #1;
         if (rd_seen && fifo_q.size() > 0) void'(fifo_q.pop_front());
         i_fifo_empty = (fifo_q.size() == 0);
         i_fifo_data  = (fifo_q.size() == 0) ? '0 : fifo_q[0];
      end
   end

   // Line monitor: decodes each frame from the falling start edge and scores it.
   initial begin : monitor
      logic [NB-1:0] m_bits;
      logic          start_bit;
      logic          stop_bit;
      int            k;
      int            t0;
      bit            aborted;
      bit            got_done;
      exp_t          e;
      forever begin
         @(negedge i_clk);
         if (i_reset_n === 1'b1 && o_tx === 1'b0) begin
            t0        = cyc;
            k         = 0;
            aborted   = 0;
            got_done  = 0;
            start_bit = 1'b1;
            stop_bit  = 1'b0;
            m_bits    = '0;
            while (!aborted && !got_done && k < DONE_MAX + 8) begin
               @(negedge i_clk);
               k++;
               if (i_reset_n !== 1'b1) begin
                  aborted = 1;
               end else begin
                  if (k == BIT_CLKS / 2) start_bit = o_tx;
                  for (int j = 0; j < NB; j++)
                     if (k == BIT_CLKS * (j + 1) + 30) m_bits[j] = o_tx;
                  if (k == BIT_CLKS * (NB + 1) + 30) stop_bit = o_tx;
                  if (o_tx_done_tick === 1'b1) got_done = 1;
               end
            end
            if (!aborted) begin
               check("done_seen", int'(got_done), 1);
               check("frame_expected", int'(exp_q.size() > 0), 1);
               if (exp_q.size() > 0) begin
                  e = exp_q.pop_front();
                  check("frame_word", int'(m_bits[7:0]), int'(e.word));
                  check("start_bit", int'(start_bit), 0);
                  check("stop_bit", int'(stop_bit), 1);
                  check("frame_len_ok", int'(k >= DONE_MIN && k <= DONE_MAX), 1);
`ifdef UART_TX_PARITY_EN
                  check("parity_bit", int'(m_bits[NB-1]), int'(e.par ^ PAR_ODD));
`endif
                  if (e.b2b) check("b2b_gap", t0 - last_done, 1);
                  check("busy_at_done", int'(o_busy), 0);
               end
               last_done = cyc;
            end
         end
      end
   end

   initial begin : stimulus
      i_reset_n = 1'b0;
      repeat (3) @(negedge i_clk);
      check("rst_tx", int'(o_tx), 1);
      check("rst_fifo_rd", int'(o_fifo_rd), 0);
      check("rst_busy", int'(o_busy), 0);
      check("rst_done", int'(o_tx_done_tick), 0);
      i_reset_n = 1'b1;

      // Empty FIFO: line idle, no pops.
      repeat (2000) begin
         @(negedge i_clk);
         if (o_tx !== 1'b1 || o_busy !== 1'b0) idle_bad++;
      end
      check("idle_line_bad", idle_bad, 0);
      check("idle_pops", pops, 0);

      // Single word.
      push_word(8'hA5, 1'b0, 1'b0);
      wait_drain(1500);
      check("pops_a5", pops, 1);

      // Three words back to back.
      push_word(8'h00, 1'b0, 1'b0);
      push_word(8'hFF, 1'b1, 1'b0);
      push_word(8'h3C, 1'b1, 1'b0);
      wait_drain(4000);
      check("pops_three", pops, 4);

      // Reset in the middle of the data bits: word dropped, no re-pop.
      fifo_q.push_back(8'h55);
      wait_pops(5, 200);
      repeat (BIT_CLKS * 3) @(negedge i_clk);
      #2 i_reset_n = 1'b0;
      #1;
      check("async_rst_tx", int'(o_tx), 1);
      check("async_rst_busy", int'(o_busy), 0);
      repeat (3) @(negedge i_clk);
      i_reset_n = 1'b1;
      repeat (500) @(negedge i_clk);
      check("pops_after_rst", pops, 5);
      check("idle_after_rst", int'(o_tx), 1);

      // FIFO overwritten while a frame is in flight: oldest entry discarded.
      push_word(8'h81, 1'b0, 1'b0);
      wait_pops(6, 200);
      repeat (100) @(negedge i_clk);
      fifo_q.push_back(8'h11);
      fifo_q.push_back(8'h22);
      void'(fifo_q.pop_front());
      fifo_q.push_back(8'h99);
      exp_q.push_back('{word: 8'h22, b2b: 1'b1, par: 1'b0});
      exp_q.push_back('{word: 8'h99, b2b: 1'b1, par: 1'b0});
      frames_exp += 2;
      wait_drain(4000);
      check("pops_overwrite", pops, 8);

`ifdef UART_TX_PARITY_EN
      push_word(8'h07, 1'b0, 1'b1);
      wait_drain(1500);
      check("pops_parity", pops, 9);
`endif

      check("done_pulses", done_cnt, frames_exp);
      check("illegal_pops", illegal_pops, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
